// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   Walks a raster of H_TOTAL x V_TOTAL positions (active, front porch, sync,
//   back porch in both directions) and produces registered sync, data-enable,
//   pixel coordinates and line/frame strobes that describe the current count.
// Ports:
//   PIX_CLK      pixel clock, rising edge
//   RST_N        asynchronous active-low reset
//   EN           advance enable; 0 freezes the raster
//   HS, VS       sync outputs, active level HS_POL / VS_POL
//   DE           high when both counts are in their active regions
//   PIX_X        horizontal count while DE, else 0
//   PIX_Y        vertical count while in vertical active region, else 0
//   LINE_START   one-cycle strobe when the horizontal count becomes 0
//   FRAME_START  one-cycle strobe when the position becomes (0,0)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11
) (
  input  logic          PIX_CLK,
  input  logic          RST_N,
  input  logic          EN,
  output logic          HS,
  output logic          VS,
  output logic          DE,
  output logic [CW-1:0] PIX_X,
  output logic [CW-1:0] PIX_Y,
  output logic          LINE_START,
  output logic          FRAME_START
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG   = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_BEG + H_SYNC;
  localparam int VS_BEG   = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_BEG + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);

  if (H_TOTAL - 1 > (2 ** CW) - 1) begin : g_h_width_err
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1");
  end
  if (V_TOTAL - 1 > (2 ** CW) - 1) begin : g_v_width_err
    $error("vga_timing_gen: CW too narrow for V_TOTAL-1");
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_size_err
    $error("vga_timing_gen: active and sync widths must be >= 1");
  end

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic          h_act, v_act, h_syn, v_syn;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (EN) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Outputs are decoded from the next counts so that, once registered, they
  // line up with the counter registers of the same cycle.
  always_comb begin
    h_act = int'(h_d) < H_ACTIVE;
    v_act = int'(v_d) < V_ACTIVE;
    h_syn = (int'(h_d) >= HS_BEG) && (int'(h_d) < HS_END);
    v_syn = (int'(v_d) >= VS_BEG) && (int'(v_d) < VS_END);
    hs_d  = h_syn ? HS_ACT : ~HS_ACT;
    vs_d  = v_syn ? VS_ACT : ~VS_ACT;
    de_d  = h_act && v_act;
    x_d   = de_d ? h_d : '0;
    y_d   = v_act ? v_d : '0;
    ls_d  = EN && (h_d == '0);
    fs_d  = ls_d && (v_d == '0);
  end

  // Level outputs only load while enabled: straight after reset the held
  // counts sit on the last raster position, whose decode need not match the
  // reset output values, and a stall must not disturb them.
  always_ff @(posedge PIX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_q  <= H_LAST;
      v_q  <= V_LAST;
      hs_q <= ~HS_ACT;
      vs_q <= ~VS_ACT;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      if (EN) begin
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
        x_q  <= x_d;
        y_q  <= y_d;
      end
    end
  end

  assign HS          = hs_q;
  assign VS          = vs_q;
  assign DE          = de_q;
  assign PIX_X       = x_q;
  assign PIX_Y       = y_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three vga_timing_gen instances (default 640x480
// timing, a tiny 8x6 raster, and a zero-porch raster with inverted sync
// polarity) against a raster-position model, plus hand-computed literals.
module tb_vga_timing_gen;

  localparam int HA [3] = '{640, 4, 5};
  localparam int HF [3] = '{16, 1, 0};
  localparam int HW [3] = '{96, 2, 2};
  localparam int HB [3] = '{48, 1, 0};
  localparam int VA [3] = '{480, 3, 3};
  localparam int VF [3] = '{10, 1, 0};
  localparam int VW [3] = '{2, 1, 1};
  localparam int VB [3] = '{33, 1, 0};
  localparam int HP [3] = '{0, 0, 1};
  localparam int VP [3] = '{0, 0, 1};

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lit_t;

  logic        clk;
  logic        rstn [3];
  logic        en   [3];
  logic        hs   [3];
  logic        vs   [3];
  logic        de   [3];
  logic [10:0] px   [3];
  logic [10:0] py   [3];
  logic        ls   [3];
  logic        fs   [3];

  int   total = 0;
  int   bad   = 0;
  lit_t lq[$];

  // Model state: linear position in the frame, "just reset" flag, and
  // whether the last edge advanced the raster.
  int   p     [3];
  logic fresh [3];
  logic stb   [3];

  vga_timing_gen u_def (
    .PIX_CLK(clk), .RST_N(rstn[0]), .EN(en[0]),
    .HS(hs[0]), .VS(vs[0]), .DE(de[0]), .PIX_X(px[0]), .PIX_Y(py[0]),
    .LINE_START(ls[0]), .FRAME_START(fs[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_tiny (
    .PIX_CLK(clk), .RST_N(rstn[1]), .EN(en[1]),
    .HS(hs[1]), .VS(vs[1]), .DE(de[1]), .PIX_X(px[1]), .PIX_Y(py[1]),
    .LINE_START(ls[1]), .FRAME_START(fs[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FP(0), .H_SYNC(2), .H_BP(0),
    .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(0),
    .HS_POL(1), .VS_POL(1)
  ) u_pol (
    .PIX_CLK(clk), .RST_N(rstn[2]), .EN(en[2]),
    .HS(hs[2]), .VS(vs[2]), .DE(de[2]), .PIX_X(px[2]), .PIX_Y(py[2]),
    .LINE_START(ls[2]), .FRAME_START(fs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int htot(int k);
    return HA[k] + HF[k] + HW[k] + HB[k];
  endfunction

  function automatic int ftot(int k);
    return htot(k) * (VA[k] + VF[k] + VW[k] + VB[k]);
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      p[k]     = ftot(k) - 1;
      fresh[k] = 1'b1;
      stb[k]   = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn[k]) begin
        p[k]     <= ftot(k) - 1;
        fresh[k] <= 1'b1;
        stb[k]   <= 1'b0;
      end else if (en[k]) begin
        p[k]     <= (p[k] + 1) % ftot(k);
        fresh[k] <= 1'b0;
        stb[k]   <= 1'b1;
      end else begin
        stb[k]   <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model check of every instance each cycle, then
  // any literal expectations queued by the stimulus.
  int   ch, cv, e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs;
  lit_t r;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ch = p[k] % htot(k);
      cv = p[k] / htot(k);
      if (!rstn[k] || fresh[k]) begin
        e_hs = 1 - HP[k];
        e_vs = 1 - VP[k];
        e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
      end else begin
        e_hs = (ch >= HA[k] + HF[k] && ch < HA[k] + HF[k] + HW[k]) ? HP[k] : 1 - HP[k];
        e_vs = (cv >= VA[k] + VF[k] && cv < VA[k] + VF[k] + VW[k]) ? VP[k] : 1 - VP[k];
        e_de = (ch < HA[k] && cv < VA[k]) ? 1 : 0;
        e_x  = (e_de != 0) ? ch : 0;
        e_y  = (cv < VA[k]) ? cv : 0;
        e_ls = (stb[k] && ch == 0) ? 1 : 0;
        e_fs = (stb[k] && p[k] == 0) ? 1 : 0;
      end
      check($sformatf("hs%0d", k), int'(hs[k]), e_hs);
      check($sformatf("vs%0d", k), int'(vs[k]), e_vs);
      check($sformatf("de%0d", k), int'(de[k]), e_de);
      check($sformatf("x%0d", k),  int'(px[k]), e_x);
      check($sformatf("y%0d", k),  int'(py[k]), e_y);
      check($sformatf("ls%0d", k), int'(ls[k]), e_ls);
      check($sformatf("fs%0d", k), int'(fs[k]), e_fs);
    end
    while (lq.size() > 0) begin
      r = lq.pop_front();
      check(r.name, r.act, r.exp);
    end
  end

  task automatic lit(input string n, input int a, input int e);
    lit_t t;
    t.name = n; t.act = a; t.exp = e;
    lq.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int de_cnt, fs_cnt, fs_off;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0;
      en[k]   = 1'b0;
    end
    repeat (3) tick();
    lit("rst_hs_def", int'(hs[0]), 1);
    lit("rst_vs_def", int'(vs[0]), 1);
    lit("rst_de_def", int'(de[0]), 0);
    lit("rst_hs_pol", int'(hs[2]), 0);
    lit("rst_vs_pol", int'(vs[2]), 0);

    // Default timing: first edge, stall before sync, line wrap, mid-line reset.
    rstn[0] = 1'b1; en[0] = 1'b1;
    tick();
    lit("first_x", int'(px[0]), 0);
    lit("first_y", int'(py[0]), 0);
    lit("first_de", int'(de[0]), 1);
    lit("first_ls", int'(ls[0]), 1);
    lit("first_fs", int'(fs[0]), 1);
    repeat (655) tick();
    lit("h655_hs", int'(hs[0]), 1);
    lit("h655_de", int'(de[0]), 0);
    en[0] = 1'b0;
    repeat (5) tick();
    lit("stall_hs", int'(hs[0]), 1);
    lit("stall_ls", int'(ls[0]), 0);
    en[0] = 1'b1;
    tick();
    lit("h656_hs", int'(hs[0]), 0);
    repeat (143) tick();
    lit("h799_hs", int'(hs[0]), 1);
    tick();
    lit("line1_ls", int'(ls[0]), 1);
    lit("line1_fs", int'(fs[0]), 0);
    lit("line1_y", int'(py[0]), 1);
    repeat (300) tick();
    lit("h300_x", int'(px[0]), 300);
    lit("h300_y", int'(py[0]), 1);
    rstn[0] = 1'b0;
    #1;
    lit("arst_de", int'(de[0]), 0);
    lit("arst_x", int'(px[0]), 0);
    lit("arst_y", int'(py[0]), 0);
    tick();
    tick();
    rstn[0] = 1'b1;
    tick();
    lit("restart_fs", int'(fs[0]), 1);
    lit("restart_x", int'(px[0]), 0);
    lit("restart_de", int'(de[0]), 1);
    en[0] = 1'b0;

    // Tiny raster: three full 48-cycle frames.
    rstn[1] = 1'b1; en[1] = 1'b1;
    de_cnt = 0; fs_cnt = 0; fs_off = 0;
    for (int i = 0; i < 144; i++) begin
      tick();
      if (de[1]) de_cnt++;
      if (fs[1]) begin
        fs_cnt++;
        if (i % 48 != 0) fs_off++;
      end
      if (i == 5) lit("tiny_h5_hs", int'(hs[1]), 0);
      if (i == 7) lit("tiny_h7_hs", int'(hs[1]), 1);
      if (i == 9) begin
        lit("tiny_p9_x", int'(px[1]), 1);
        lit("tiny_p9_y", int'(py[1]), 1);
      end
      if (i == 33) begin
        lit("tiny_v4_vs", int'(vs[1]), 0);
        lit("tiny_v4_de", int'(de[1]), 0);
      end
    end
    lit("tiny_de_count", de_cnt, 36);
    lit("tiny_fs_count", fs_cnt, 3);
    lit("tiny_fs_period", fs_off, 0);
    en[1] = 1'b0;

    // Zero-porch raster with active-high syncs.
    rstn[2] = 1'b1; en[2] = 1'b1;
    de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 84; i++) begin
      tick();
      if (de[2]) de_cnt++;
      if (fs[2]) fs_cnt++;
      if (i == 4) begin
        lit("pol_h4_x", int'(px[2]), 4);
        lit("pol_h4_hs", int'(hs[2]), 0);
      end
      if (i == 5) lit("pol_h5_hs", int'(hs[2]), 1);
      if (i == 21) begin
        lit("pol_v3_vs", int'(vs[2]), 1);
        lit("pol_v3_y", int'(py[2]), 0);
      end
    end
    lit("pol_de_count", de_cnt, 45);
    lit("pol_fs_count", fs_cnt, 3);
    en[2] = 1'b0;

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
